// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_controller
// Brief    : Control sequencer in front of a 4-way set-associative tag array.
//            It handles lookup, line fill, write-through and round-robin victim
//            selection.
// Revision : 1.0 - initial release
// ============================================================================
module cache_controller #(
    parameter int ADDR_WIDTH    = 32,
    parameter int TAG_BITS      = 19,
    parameter int INDEX_BITS    = 7,
    parameter int OFFSET_BITS   = 6,
    parameter int ASSOCIATIVITY = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cpu_req,
    input  logic                             cpu_we,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    output logic                             cpu_ready,
    output logic                             cpu_hit,
    output logic [INDEX_BITS-1:0]            ta_set_index,
    output logic [TAG_BITS-1:0]              ta_tag,
    output logic                             ta_read,
    output logic                             ta_write_enable,
    output logic [$clog2(ASSOCIATIVITY)-1:0] ta_update_way,
    input  logic                             ta_hit,
    input  logic [$clog2(ASSOCIATIVITY)-1:0] ta_way,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic                             mem_ready
);

    localparam int c_WAY_BITS = $clog2(ASSOCIATIVITY);
    localparam int c_SETS     = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_FILL      = 3'd2,
        ST_UPDATE    = 3'd3,
        ST_WRITE_MEM = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_req_addr;
    logic                    r_req_we;
    logic                    r_hit;
    logic [c_WAY_BITS-1:0]   r_rr_ptr [c_SETS];
    logic [INDEX_BITS-1:0]   w_index;
    logic [TAG_BITS-1:0]     w_tag;
    logic                    w_unused_way;

    assign w_index      = r_req_addr[OFFSET_BITS +: INDEX_BITS];
    assign w_tag        = r_req_addr[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
    // The hitting way matters only to the data-array stage.
    assign w_unused_way = ^ta_way;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_req_addr <= '0;
            r_req_we   <= 1'b0;
            r_hit      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && cpu_req) begin
                r_req_addr <= cpu_addr;
                r_req_we   <= cpu_we;
            end
            if (r_state == ST_LOOKUP) begin
                r_hit <= ta_hit;
            end
        end
    end

    // Victim pointer advances only on an actual install; the width wraps 3 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_SETS; i++) begin
                r_rr_ptr[i] <= '0;
            end
        end else if (r_state == ST_UPDATE) begin
            r_rr_ptr[w_index] <= r_rr_ptr[w_index] + 1'b1;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        cpu_ready       = 1'b0;
        cpu_hit         = 1'b0;
        ta_read         = 1'b0;
        ta_write_enable = 1'b0;
        ta_update_way   = '0;
        ta_set_index    = '0;
        ta_tag          = '0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;

        if (r_state != ST_IDLE) begin
            ta_set_index = w_index;
            ta_tag       = w_tag;
        end

        case (r_state)
            ST_IDLE: begin
                if (cpu_req) begin
                    w_state_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                ta_read = 1'b1;
                if (r_req_we) begin
                    w_state_next = ST_WRITE_MEM;
                end else if (ta_hit) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_req_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                if (mem_ready) begin
                    w_state_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                ta_write_enable = 1'b1;
                ta_update_way   = r_rr_ptr[w_index];
                w_state_next    = ST_DONE;
            end
            ST_WRITE_MEM: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = r_req_addr;
                if (mem_ready) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                cpu_ready    = 1'b1;
                cpu_hit      = r_hit;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_controller
// Brief    : Directed and random requests with a tag-array model and a
//            transaction-level reference of hits, victims and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        cpu_ready;
    logic        cpu_hit;
    logic [6:0]  ta_set_index;
    logic [18:0] ta_tag;
    logic        ta_read;
    logic        ta_write_enable;
    logic [1:0]  ta_update_way;
    logic        ta_hit;
    logic [1:0]  ta_way;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_ready       (cpu_ready),
        .cpu_hit         (cpu_hit),
        .ta_set_index    (ta_set_index),
        .ta_tag          (ta_tag),
        .ta_read         (ta_read),
        .ta_write_enable (ta_write_enable),
        .ta_update_way   (ta_update_way),
        .ta_hit          (ta_hit),
        .ta_way          (ta_way),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready)
    );

    // Tag array environment: installs on ta_write_enable, never cleared by rst.
    logic [18:0] env_tag [128][4];
    bit          env_vld [128][4];

    always @(posedge clk) begin
        if (ta_write_enable) begin
            env_tag[ta_set_index][ta_update_way] <= ta_tag;
            env_vld[ta_set_index][ta_update_way] <= 1'b1;
        end
    end

    always_comb begin
        ta_hit = 1'b0;
        ta_way = 2'd0;
        if (ta_read) begin
            for (int w = 0; w < 4; w++) begin
                if (env_vld[ta_set_index][w] && env_tag[ta_set_index][w] == ta_tag) begin
                    ta_hit = 1'b1;
                    ta_way = w[1:0];
                end
            end
        end
    end

    // Reference: which tags each set holds and whose turn it is to be evicted.
    int ref_tag [128][4];
    bit ref_vld [128][4];
    int ref_rr  [128];

    function automatic bit ref_hit(input logic [31:0] a);
        int idx;
        int tg;
        bit h;
        idx = int'((a >> 6) % 128);
        tg  = int'(a >> 13);
        h   = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if (ref_vld[idx][w] && ref_tag[idx][w] == tg) h = 1'b1;
        end
        return h;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit any_out();
        return |{cpu_ready, cpu_hit, ta_read, ta_write_enable, ta_update_way,
                 ta_set_index, ta_tag, mem_req, mem_we, mem_addr};
    endfunction

    // Issue one request from an IDLE cycle; returns at the negedge of the IDLE after DONE.
    task automatic do_req(input bit we, input logic [31:0] addr, input int k, input bit busy);
        int idx, tg, exp_lat, cyc, mem_cyc, inst_cnt, inst_way, done_cyc;
        bit exp_hit, got_hit, fill;
        logic [31:0] exp_maddr;
        idx       = int'((addr >> 6) % 128);
        tg        = int'(addr >> 13);
        exp_hit   = ref_hit(addr);
        fill      = !we && !exp_hit;
        exp_maddr = we ? addr : (addr / 64) * 64;
        exp_lat   = we ? 3 + k : (exp_hit ? 2 : 4 + k);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        @(negedge clk);
        cyc = 1; mem_cyc = 0; inst_cnt = 0; inst_way = -1; done_cyc = 0; got_hit = 1'b0;
        while (done_cyc == 0 && cyc < 60) begin
            if (busy && $urandom_range(1, 0) == 1) begin
                cpu_req  = 1'b1;
                cpu_we   = ~we;
                cpu_addr = addr ^ 32'hA5A0_0000;
            end else begin
                cpu_req = 1'b0;
            end
            if (cyc == 1) chk("lookup_read", ta_read, 1);
            chk("ta_set_index", ta_set_index, idx);
            chk("ta_tag", ta_tag, tg);
            mem_ready = 1'b0;
            if (mem_req) begin
                mem_cyc++;
                chk("mem_addr", mem_addr, exp_maddr);
                chk("mem_we", mem_we, we);
                if (mem_cyc == k + 1) mem_ready = 1'b1;
            end
            if (ta_write_enable) begin
                inst_cnt++;
                inst_way = int'(ta_update_way);
            end
            if (cpu_ready) begin
                done_cyc = cyc;
                got_hit  = cpu_hit;
            end else begin
                chk("hit_outside_ready", cpu_hit, 0);
                @(negedge clk);
                cyc++;
            end
        end
        mem_ready = 1'b0;
        chk("timeout", done_cyc != 0, 1);
        chk("latency", done_cyc, exp_lat);
        chk("cpu_hit", got_hit, exp_hit);
        chk("mem_cycles", mem_cyc, (we || !exp_hit) ? k + 1 : 0);
        chk("installs", inst_cnt, fill ? 1 : 0);
        if (fill) begin
            chk("victim_way", inst_way, ref_rr[idx]);
            ref_tag[idx][ref_rr[idx]] = tg;
            ref_vld[idx][ref_rr[idx]] = 1'b1;
            ref_rr[idx] = (ref_rr[idx] + 1) % 4;
        end
        @(negedge clk);
        cpu_req = 1'b0;
        chk("idle_no_ready", cpu_ready, 0);
        chk("idle_outputs", any_out(), 0);
    endtask

    // Read miss aborted by reset in its second FILL cycle.
    task automatic do_reset_fill(input logic [31:0] addr);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = addr;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("rf_lookup", ta_read, 1);
        @(negedge clk);
        chk("rf_fill1", mem_req, 1);
        @(negedge clk);
        chk("rf_fill2", mem_req, 1);
        rst = 1'b1;
        #1;
        chk("rf_mem_req_drop", mem_req, 0);
        chk("rf_outputs", any_out(), 0);
        for (int i = 0; i < 128; i++) ref_rr[i] = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rf_no_ready", cpu_ready, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rf_idle", any_out(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_1040;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", any_out(), 0);
        end
        rst = 1'b0;

        do_req(1'b0, 32'h0000_1040, 2, 1'b0);
        do_req(1'b0, 32'h0000_1040, 0, 1'b0);
        do_req(1'b1, 32'h0000_1044, 1, 1'b0);
        do_req(1'b1, 32'h0008_0000, 0, 1'b0);

        do_reset_fill(32'h0000_E040);

        for (int t = 1; t <= 5; t++) begin
            a = (t << 13) | (65 << 6);
            do_req(1'b0, a, 0, 1'b0);
        end
        do_req(1'b0, 32'h0000_2080, 0, 1'b0);

        do_req(1'b0, 32'h0000_C040, 2, 1'b1);
        do_req(1'b0, 32'h0000_2080, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(5, 0) << 13) | ($urandom_range(66, 64) << 6) | $urandom_range(63, 0);
            do_req($urandom_range(3, 0) == 0, a, int'($urandom_range(3, 0)), $urandom_range(1, 0) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
